// File: rtl/adder_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin adder arbiter.
package adder_arbiter_pkg;

  localparam int DEF_NREQ  = 3;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin selector: first requester above last_grant wins, wrapping at NREQ.
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] idx_o
);

  logic            found_s;
  logic [IDXW:0]   cand_wide_s;
  logic [IDXW:0]   cand_wrap_s;
  logic [IDXW-1:0] cand_s;

  // Scan candidates (last+1 .. last+NREQ) mod NREQ, keep the first active one
  always_comb begin
    grant_o     = '0;
    idx_o       = '0;
    found_s     = 1'b0;
    cand_wide_s = '0;
    cand_wrap_s = '0;
    cand_s      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_wide_s = {1'b0, last_grant_i} + (IDXW+1)'(k);
      if (cand_wide_s >= (IDXW+1)'(NREQ)) begin
        cand_wrap_s = cand_wide_s - (IDXW+1)'(NREQ);
      end else begin
        cand_wrap_s = cand_wide_s;
      end
      cand_s = cand_wrap_s[IDXW-1:0];
      if (!found_s && req_i[cand_s]) begin
        found_s         = 1'b1;
        grant_o[cand_s] = 1'b1;
        idx_o           = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered adder among NREQ requesters: IDLE grants, ADD computes,
// DONE holds the result for the captured requester until it is accepted.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_carry,
  output logic                  resp_ovf,
  output logic                  busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  last_q, last_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d, ovf_q, ovf_d;

  logic [NREQ-1:0]  grant_s, ready_s;
  logic [IDXW-1:0]  gidx_s;
  logic [WIDTH-1:0] sel_op1_s, sel_op2_s;
  logic [WIDTH:0]   sum_full_s;

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant_s),
    .idx_o        (gidx_s)
  );

  // One-hot operand mux driven by the arbiter grant
  always_comb begin
    sel_op1_s = '0;
    sel_op2_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        sel_op1_s = sel_op1_s | req_op1[i*WIDTH +: WIDTH];
        sel_op2_s = sel_op2_s | req_op2[i*WIDTH +: WIDTH];
      end else begin
        sel_op1_s = sel_op1_s;
        sel_op2_s = sel_op2_s;
      end
    end
  end

  assign sum_full_s = {1'b0, op1_q} + {1'b0, op2_q};

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ready_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          ready_s = grant_s;
          last_d  = gidx_s;
          idx_d   = gidx_s;
          op1_d   = sel_op1_s;
          op2_d   = sel_op2_s;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        sum_d   = sum_full_s[WIDTH-1:0];
        carry_d = sum_full_s[WIDTH];
        ovf_d   = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) &&
                  (sum_full_s[WIDTH-1] != op1_q[WIDTH-1]);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready[idx_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      idx_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  // Response valid decoded from registered state and captured index
  always_comb begin
    resp_valid = '0;
    if (state_q == ST_DONE) begin
      resp_valid[idx_q] = 1'b1;
    end else begin
      resp_valid = '0;
    end
  end

  // Grant is combinational, so mask it while reset is held
  assign req_ready  = ready_s & {NREQ{reset}};
  assign resp_sum   = sum_q;
  assign resp_carry = carry_q;
  assign resp_ovf   = ovf_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table of single ops plus
// fairness, backpressure and mid-operation reset sequences.
module tb_adder_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 32;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_op1, req_op2;
  logic [NREQ-1:0]       req_ready, resp_valid, resp_ready;
  logic [WIDTH-1:0]      resp_sum;
  logic                  resp_carry, resp_ovf, busy;

  int errors = 0;
  int checks = 0;

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_carry(resp_carry), .resp_ovf(resp_ovf),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
    req_op1[r*WIDTH +: WIDTH] = a;
    req_op2[r*WIDTH +: WIDTH] = b;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [NREQ-1:0] oh;
    oh = 3'b001 << v.req;
    set_ops(v.req, v.a, v.b);
    req_valid  = oh;
    resp_ready = oh;
    #1;
    check($sformatf("v%0d grant", n), 64'(req_ready), 64'(oh));
    check($sformatf("v%0d idle_busy", n), 64'(busy), 64'd0);
    step();
    req_valid = 3'b000;
    #1;
    check($sformatf("v%0d add_busy", n), 64'(busy), 64'd1);
    check($sformatf("v%0d add_rvalid", n), 64'(resp_valid), 64'd0);
    step();
    check($sformatf("v%0d rvalid", n), 64'(resp_valid), 64'(oh));
    check($sformatf("v%0d sum", n), 64'(resp_sum), 64'(v.sum));
    check($sformatf("v%0d carry", n), 64'(resp_carry), 64'(v.carry));
    check($sformatf("v%0d ovf", n), 64'(resp_ovf), 64'(v.ovf));
    step();
    check($sformatf("v%0d back_idle", n), 64'(busy), 64'd0);
    check($sformatf("v%0d sum_kept", n), 64'(resp_sum), 64'(v.sum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000,  1'b1, 1'b0};
    vecs[2] = '{2, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1};
    vecs[3] = '{0, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  1'b1, 1'b1};
    vecs[4] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b1, 1'b0};
    vecs[5] = '{2, 32'd0,          32'd0,          32'd0,          1'b0, 1'b0};
    vecs[6] = '{0, 32'h1234_5678,  32'h1111_1111,  32'h2345_6789,  1'b0, 1'b0};
    vecs[7] = '{1, 32'h8000_0000,  32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0};

    reset = 1'b0;
    req_valid = '0; req_op1 = '0; req_op2 = '0; resp_ready = '0;
    #1;
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst sum", 64'(resp_sum), 64'd0);
    check("rst carry_ovf", 64'({resp_carry, resp_ovf}), 64'd0);
    step();
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Fairness: all three hold requests, grants rotate 0,1,2,0,1,2 every 3 cycles
    reset = 1'b0; #1; reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1), 32'(100 * (i + 1)));
    req_valid = 3'b111; resp_ready = 3'b111;
    #1;
    for (int g = 0; g < 6; g++) begin
      check($sformatf("fair%0d grant", g), 64'(req_ready), 64'(3'b001 << (g % 3)));
      step();
      check($sformatf("fair%0d add_noready", g), 64'(req_ready), 64'd0);
      step();
      check($sformatf("fair%0d done_noready", g), 64'(req_ready), 64'd0);
      check($sformatf("fair%0d rvalid", g), 64'(resp_valid), 64'(3'b001 << (g % 3)));
      check($sformatf("fair%0d sum", g), 64'(resp_sum), 64'(101 * ((g % 3) + 1)));
      step();
    end
    // Leaving that loop at a fresh IDLE with last_grant = 2

    // Backpressure on requester 1; other resp_ready bits must be ignored
    req_valid = 3'b010; resp_ready = 3'b000;
    #1;
    check("bp grant", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = 3'b111; resp_ready = 3'b101;
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d rvalid", c), 64'(resp_valid), 64'(3'b010));
      check($sformatf("bp%0d sum", c), 64'(resp_sum), 64'd202);
      check($sformatf("bp%0d req_ready", c), 64'(req_ready), 64'd0);
      step();
    end
    resp_ready = 3'b010;
    #1;
    step();
    check("bp released idle", 64'(resp_valid), 64'd0);
    check("bp next grant", 64'(req_ready), 64'(3'b100));
    step();
    req_valid = 3'b000; resp_ready = 3'b111;
    step();
    step();
    check("bp drain idle", 64'(busy), 64'd0);

    // Reset during ADD discards the operation
    req_valid = 3'b001;
    step();
    check("mid busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst req_ready", 64'(req_ready), 64'd0);
    check("mid rst resp_valid", 64'(resp_valid), 64'd0);
    check("mid rst sum", 64'(resp_sum), 64'd0);
    check("mid rst carry_ovf", 64'({resp_carry, resp_ovf}), 64'd0);
    step();
    check("mid held no resp", 64'(resp_valid), 64'd0);
    reset = 1'b1;
    req_valid = 3'b100;
    #1;
    check("mid grant2", 64'(req_ready), 64'(3'b100));
    step();
    req_valid = 3'b111;
    step();
    check("mid rvalid2", 64'(resp_valid), 64'(3'b100));
    check("mid sum2", 64'(resp_sum), 64'd303);
    step();
    check("mid next grant0", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = 3'b000;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
